// File: rtl/mux_sel_ctrl.sv
// rtl/mux_sel_ctrl.sv - select debounce and data guard controller for the 2:1 conditional mux (optional switch counter: MUX_SEL_CTRL_COUNT_EN)
module mux_sel_ctrl #(
    parameter int DEB_CYCLES   = 4,
    parameter int GUARD_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel_req,
    input  logic             i0_in,
    input  logic             i1_in,
    output logic             s,
    output logic             i0,
    output logic             i1,
    output logic             busy,
    output logic [CNT_W-1:0] sw_count
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, GUARD} state_t;

    localparam logic [7:0] DEB_L   = 8'(DEB_CYCLES);
    localparam logic [7:0] GUARD_L = 8'(GUARD_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] deb_q, deb_d;
    logic [7:0] grd_q, grd_d;
    logic       s_q, s_d;
    logic       i0_q, i1_q;
    logic       busy_q, busy_d;
    logic       flip;
    logic       load;

    // Next-state logic: debounce the select request, flip s, then hold data for the guard window
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        grd_d   = grd_q;
        flip    = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_req != s_q) begin
                    if (DEB_CYCLES == 1) begin
                        flip    = 1'b1;
                        grd_d   = 8'd0;
                        state_d = GUARD;
                    end else begin
                        load    = 1'b1;
                        deb_d   = 8'd1;
                        state_d = DEBOUNCE;
                    end
                end else begin
                    load = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (sel_req == s_q) begin
                    // glitch: request went away before enough consecutive samples
                    load    = 1'b1;
                    deb_d   = 8'd0;
                    state_d = IDLE;
                end else if (deb_q + 8'd1 == DEB_L) begin
                    flip    = 1'b1;
                    deb_d   = 8'd0;
                    grd_d   = 8'd0;
                    state_d = GUARD;
                end else begin
                    load  = 1'b1;
                    deb_d = deb_q + 8'd1;
                end
            end
            GUARD: begin
                // sel_req is deliberately ignored here; data stays frozen
                if (grd_q + 8'd1 == GUARD_L) begin
                    grd_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    grd_d = grd_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                deb_d   = 8'd0;
                grd_d   = 8'd0;
            end
        endcase
        s_d    = s_q ^ flip;
        busy_d = (state_d != IDLE);
    end

    // State, select and data registers; data loads only on non-flip edges outside GUARD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            deb_q   <= 8'd0;
            grd_q   <= 8'd0;
            s_q     <= 1'b0;
            i0_q    <= 1'b0;
            i1_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            grd_q   <= grd_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            if (load) begin
                i0_q <= i0_in;
                i1_q <= i1_in;
            end
        end
    end

`ifdef MUX_SEL_CTRL_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] cnt_q;

    // Completed-flip counter, saturating at all ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (flip && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sw_count = cnt_q;
`else
    assign sw_count = '0;
`endif

    assign s    = s_q;
    assign i0   = i0_q;
    assign i1   = i1_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// tb/tb_mux_sel_ctrl.sv - self-checking bench for mux_sel_ctrl
module tb_mux_sel_ctrl;

    localparam int DEB   = 4;
    localparam int GUARD = 2;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;
`ifdef MUX_SEL_CTRL_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sel_req = 1'b0;
    logic          i0_in = 1'b0;
    logic          i1_in = 1'b0;
    logic          s, i0, i1, busy;
    logic [CW-1:0] sw_count;

    int errors = 0;
    int checks = 0;

    mux_sel_ctrl #(.DEB_CYCLES(DEB), .GUARD_CYCLES(GUARD), .CNT_W(CW)) dut (
        .clk(clk), .reset(rst), .sel_req(sel_req), .i0_in(i0_in), .i1_in(i1_in),
        .s(s), .i0(i0), .i1(i1), .busy(busy), .sw_count(sw_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: count consecutive mismatching samples, then freeze for GUARD edges
    int m_run = 0;
    int m_frz = 0;
    int m_cnt = 0;
    bit m_s = 0, m_i0 = 0, m_i1 = 0, m_busy = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_frz = 0; m_cnt = 0;
            m_s = 0; m_i0 = 0; m_i1 = 0; m_busy = 0;
        end else begin
            if (m_frz > 0) begin
                m_frz = m_frz - 1;
            end else begin
                m_run = (sel_req != m_s) ? m_run + 1 : 0;
                if (m_run == DEB) begin
                    m_s   = ~m_s;
                    m_run = 0;
                    m_frz = GUARD;
                    if (CNT_EN && m_cnt < CMAX) m_cnt = m_cnt + 1;
                end else begin
                    m_i0 = i0_in;
                    m_i1 = i1_in;
                end
            end
            m_busy = (m_run > 0) || (m_frz > 0);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("cmp_s", int'(s), int'(m_s));
        chk("cmp_i0", int'(i0), int'(m_i0));
        chk("cmp_i1", int'(i1), int'(m_i1));
        chk("cmp_busy", int'(busy), int'(m_busy));
        chk("cmp_sw_count", int'(sw_count), m_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_s", int'(s), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sw", int'(sw_count), 0);
        rst = 1'b0;
        tick();

        // Clean switch, guard freeze with toggling i0_in, and a request arriving during GUARD
        for (int e = 1; e <= 12; e++) begin
            sel_req = (e >= 5) ? 1'b0 : 1'b1;
            i0_in   = (e == 7) ? 1'b0 : e[0];
            i1_in   = ~i0_in;
            tick();
            case (e)
                1:  chk("clean_busy_e1", int'(busy), 1);
                3:  chk("clean_i0_e3", int'(i0), 1);
                4: begin
                    chk("clean_s_e4", int'(s), 1);
                    chk("clean_i0_frozen_e4", int'(i0), 1);
                    chk("clean_sw_e4", int'(sw_count), CNT_EN ? 1 : 0);
                end
                5:  chk("clean_i0_frozen_e5", int'(i0), 1);
                6: begin
                    chk("clean_busy_e6", int'(busy), 0);
                    chk("clean_i0_frozen_e6", int'(i0), 1);
                end
                7: begin
                    chk("resume_i0_e7", int'(i0), 0);
                    chk("resume_i1_e7", int'(i1), 1);
                    chk("redeb_busy_e7", int'(busy), 1);
                end
                9:  chk("redeb_s_e9", int'(s), 1);
                10: begin
                    chk("redeb_s_e10", int'(s), 0);
                    chk("redeb_sw_e10", int'(sw_count), CNT_EN ? 2 : 0);
                end
                12: chk("redeb_busy_e12", int'(busy), 0);
                default: ;
            endcase
        end

        // Glitch reject: two mismatching samples, then back
        for (int e = 1; e <= 4; e++) begin
            sel_req = (e <= 2);
            i0_in   = e[1];
            i1_in   = e[0];
            tick();
            if (e == 2) chk("glitch_busy_e2", int'(busy), 1);
            if (e == 3) begin
                chk("glitch_busy_e3", int'(busy), 0);
                chk("glitch_s_e3", int'(s), 0);
                chk("glitch_i0_e3", int'(i0), 1);
                chk("glitch_i1_e3", int'(i1), 1);
            end
        end

        // DEB-1 mismatches is one short of a flip
        for (int e = 1; e <= 5; e++) begin
            sel_req = (e <= DEB - 1);
            tick();
        end
        chk("deb_minus1_s", int'(s), 0);
        chk("deb_minus1_sw", int'(sw_count), CNT_EN ? 2 : 0);

        // Three more flips: five in total, counter saturates
        for (int f = 0; f < 3; f++) begin
            sel_req = ~f[0];
            repeat (8) tick();
        end
        chk("sat_s", int'(s), 1);
        chk("sat_sw", int'(sw_count), CNT_EN ? CMAX : 0);

        // Asynchronous reset mid-cycle with s=1 and i0=1
        i0_in = 1'b1;
        tick();
        chk("pre_rst_i0", int'(i0), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_s", int'(s), 0);
        chk("async_rst_i0", int'(i0), 0);
        chk("async_rst_i1", int'(i1), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_sw", int'(sw_count), 0);
        tick();
        rst = 1'b0;
        sel_req = 1'b0;
        repeat (3) tick();
        chk("post_rst_i0", int'(i0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_sel_ctrl.md
Name: mux_sel_ctrl

Overview:
- Upstream control stage for the 2:1 conditional mux.
- Registers the two data inputs and drives the mux select `s`.
- Debounces select requests and freezes the data lines for a guard window around every select flip, so the mux output never sees a data edge and a select edge at once.
- Outputs `s`, `i0` and `i1` connect directly to the mux ports of the same names.

Parameters:
- DEB_CYCLES, 4, consecutive sampled edges of mismatching sel_req needed before s flips (legal range 1..255).
- GUARD_CYCLES, 2, edges after a flip during which i0/i1 stay frozen (legal range 1..255).
- CNT_W, 8, width of the switch counter sw_count.

Ports:
- clk  input  1  single clock, rising-edge active.
- reset  input  1  asynchronous, active-high; all state cleared immediately.
- sel_req  input  1  requested select value.
- i0_in  input  1  raw data for mux input 0.
- i1_in  input  1  raw data for mux input 1.
- s  output  1  registered select to the mux.
- i0  output  1  registered data to mux input 0.
- i1  output  1  registered data to mux input 1.
- busy  output  1  high while a select change is pending or guarding.
- sw_count  output  CNT_W  number of completed select flips.

Behaviour:
- Reset values (asynchronous, immediate, including mid-DEBOUNCE or mid-GUARD):
  - state = IDLE; s, i0, i1, busy all 0.
  - sw_count = 0; both internal counters = 0.
- States: IDLE, DEBOUNCE, GUARD. busy = 1 in DEBOUNCE and GUARD; 0 in IDLE. busy is registered, so it follows the state.
- Data path:
  - On every edge where the current state is IDLE or DEBOUNCE and the edge is not a flip edge: i0 <= i0_in, i1 <= i1_in. Latency is 1 cycle.
  - On the flip edge and on every edge spent in GUARD, i0/i1 hold their value.
- IDLE:
  - sel_req == s: stay in IDLE.
  - sel_req != s and DEB_CYCLES == 1: flip this edge (s <= ~s), go to GUARD.
  - sel_req != s and DEB_CYCLES > 1: debounce count <= 1, go to DEBOUNCE.
- DEBOUNCE:
  - sel_req == s at an edge: count <= 0, return to IDLE, no flip. This is a glitch reject.
  - Mismatch and count + 1 == DEB_CYCLES: flip s, go to GUARD, guard count <= 0.
  - Otherwise count increments.
  - Net effect: s changes on the edge at which the DEB_CYCLES-th consecutive mismatch is sampled.
- GUARD:
  - Guard count increments each edge.
  - On the edge where it reaches GUARD_CYCLES: go to IDLE; i0/i1 do not load on that edge.
  - sel_req is ignored throughout GUARD. A mismatch still present in IDLE starts a fresh debounce.
- Total data freeze per flip = 1 + GUARD_CYCLES edges.
- sw_count increments on each flip edge and saturates at 2^CNT_W - 1 (no wrap).
- Simultaneous events: a data input change on the flip edge is not captured. The first capture happens on the first edge taken in IDLE after GUARD.

Optional Feature:
- MUX_SEL_CTRL_COUNT_EN defined: sw_count operates as described above.
- Not defined:
  - Counter logic is removed and sw_count is tied to 0.
  - The port is still present.
  - All other behaviour is identical.

Test Plan:
- Reset: assert reset mid-cycle while s = 1 and i0 = 1 -> s, i0, i1, busy, sw_count read 0 immediately, before the next clk edge.
- Clean switch (DEB = 4, GUARD = 2): sel_req 0->1 before edge E1, held -> busy = 1 after E1; s = 1 after E4; sw_count = 1; busy = 0 after E6.
- Glitch reject (DEB = 4): sel_req high for 2 edges, then low -> s stays 0, busy returns to 0, sw_count = 0, i0/i1 track throughout.
- Guard freeze: toggle i0_in every cycle across a flip at E4 -> i0 is constant over E4..E6; tracking resumes at E7 with 1-cycle latency.
- Request during GUARD: sel_req 1->0 at E5 and held -> ignored until IDLE; a new debounce starts at E7; s = 0 after E10; sw_count = 2.
- Saturation (CNT_W = 2, macro defined): 5 completed flips -> sw_count = 3. With the macro undefined -> sw_count = 0 throughout.
